// File: rtl/tx_pkg.sv
`default_nettype none
// =============================================================================
// Module      : tx_pkg
// Description : Shared FSM state encoding and frame constants for uio_byte_tx.
// Revision    : 1.0 - initial release
// =============================================================================
package tx_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// =============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO; full/empty derived from a level counter.
// Revision    : 1.0 - initial release
// =============================================================================
module byte_fifo
    import tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             head_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          ready_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              ready_q;
    logic              w_push;
    logic              w_pop;

    // Ready is the registered view of the level, so a full FIFO refuses even while popping.
    assign w_push = push_i & ready_q;
    assign w_pop  = pop_i & (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign ready_o = ready_q;

endmodule
`default_nettype wire

// File: rtl/uio_byte_tx.sv
`default_nettype none
// =============================================================================
// Module      : uio_byte_tx
// Description : FIFO-buffered 8N1 serial transmitter driving one uio pad.
// Revision    : 1.0 - initial release
// =============================================================================
module uio_byte_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_oe,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import tx_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    tx_state_e          state_q;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_q;
    logic [DATA_W-1:0]  shift_q;
    logic               tx_q;
    logic               oe_q;
    logic               busy_q;

    logic [DATA_W-1:0]  w_head;
    logic               w_has_data;
    logic               w_bit_end;
    logic               w_pop;

    assign w_has_data = (fifo_level != '0);
    assign w_bit_end  = (div_q == DIV_W'(CLK_DIV - 1));
    // Head is consumed when leaving IDLE, or at the end of a stop bit for a gapless next frame.
    assign w_pop      = w_has_data & ((state_q == IDLE) | ((state_q == STOP) & w_bit_end));

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_valid),
        .push_data_i (in_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .level_o     (fifo_level),
        .ready_o     (in_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            oe_q  <= 1'b1;
            div_q <= div_q + 1'b1;
            case (state_q)
                IDLE: begin
                    tx_q  <= 1'b1;
                    div_q <= '0;
                    if (w_has_data) begin
                        shift_q <= w_head;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        div_q   <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        div_q <= '0;
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        div_q <= '0;
                        if (w_has_data) begin
                            shift_q <= w_head;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx    = tx_q;
    assign tx_oe = oe_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uio_byte_tx.sv
`default_nettype none
// =============================================================================
// Module      : tb_uio_byte_tx
// Description : Scoreboard bench for uio_byte_tx at CLK_DIV = 4, 16 and 2.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_uio_byte_tx;

    localparam int N_DUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [N_DUT];
    logic       in_valid [N_DUT];
    logic [7:0] in_data  [N_DUT];
    logic       in_ready [N_DUT];
    logic       tx       [N_DUT];
    logic       tx_oe    [N_DUT];
    logic       busy     [N_DUT];
    logic [2:0] level    [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic busy_len(input int g, input int limit, output int cnt);
        cnt = 0;
        while (busy[g] === 1'b1 && cnt < limit) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : (g == 1) ? 16 : 2;
        logic [7:0] exp_q [$];

        uio_byte_tx #(
            .CLK_DIV    (DIV),
            .FIFO_DEPTH (4),
            .DATA_W     (8)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .in_data    (in_data[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .tx         (tx[g]),
            .tx_oe      (tx_oe[g]),
            .busy       (busy[g]),
            .fifo_level (level[g])
        );

        // Each start bit pops one expected byte; every cycle of the frame is compared.
        initial begin : mon
            logic [9:0] frame;
            logic [9:0] rx;
            logic       ok;
            logic       aborted;
            int         k;
            forever begin
                @(negedge clk);
                if (rst[g] !== 1'b1 && tx[g] === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("spurious_start_dut%0d", g), {31'd0, tx[g]}, 32'd1);
                        k = 0;
                        while (tx[g] !== 1'b1 && k < 20 * DIV) begin
                            @(negedge clk);
                            k++;
                        end
                    end else begin
                        frame   = {1'b1, exp_q.pop_front(), 1'b0};
                        rx      = '0;
                        ok      = 1'b1;
                        aborted = 1'b0;
                        k       = 0;
                        while (k < 10 * DIV && !aborted) begin
                            if (k != 0) @(negedge clk);
                            if (rst[g] === 1'b1 || tx_oe[g] !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                if (tx[g] !== frame[k / DIV]) ok = 1'b0;
                                if (k % DIV == DIV / 2) rx[k / DIV] = tx[g];
                            end
                            k++;
                        end
                        if (!aborted) begin
                            check($sformatf("frame_bits_dut%0d", g), {22'd0, rx}, {22'd0, frame});
                            check($sformatf("frame_timing_dut%0d", g), {31'd0, ok}, 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int   cnt;
        int   t2;
        int   t6;
        int   waited;
        int   bad;
        logic acc;

        t2 = 0;
        t6 = 0;
        for (int g = 0; g < N_DUT; g++) begin
            rst[g]      = 1'b1;
            in_valid[g] = 1'b1;
            in_data[g]  = 8'h33;
        end

        // Reset held with in_valid high: nothing may be accepted.
        repeat (5) begin
            @(negedge clk);
            check("rst_in_ready", {31'd0, in_ready[0]}, 32'd0);
            check("rst_tx",       {31'd0, tx[0]},       32'd1);
            check("rst_tx_oe",    {31'd0, tx_oe[0]},    32'd0);
            check("rst_busy",     {31'd0, busy[0]},     32'd0);
            check("rst_level",    {29'd0, level[0]},    32'd0);
        end
        for (int g = 0; g < N_DUT; g++) begin
            rst[g]      = 1'b0;
            in_valid[g] = 1'b0;
        end
        @(negedge clk);
        check("post_rst_tx_oe",    {31'd0, tx_oe[0]},    32'd1);
        check("post_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
        check("post_rst_level",    {29'd0, level[0]},    32'd0);
        check("post_rst_tx",       {31'd0, tx[0]},       32'd1);

        // Single byte 0xA5 at CLK_DIV=4.
        in_data[0]  = 8'hA5;
        in_valid[0] = 1'b1;
        g_dut[0].exp_q.push_back(8'hA5);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("t1_level_queued", {29'd0, level[0]}, 32'd1);
        check("t1_tx_still_idle", {31'd0, tx[0]},   32'd1);
        @(negedge clk);
        check("t1_start_tx",     {31'd0, tx[0]},    32'd0);
        check("t1_level_popped", {29'd0, level[0]}, 32'd0);
        busy_len(0, 200, cnt);
        check("t1_busy_len", cnt, 32'd40);
        check("t1_idle_tx",  {31'd0, tx[0]}, 32'd1);

        // Back-to-back 0x00, 0xFF: one continuous 80-cycle busy window.
        repeat (2) @(negedge clk);
        in_data[0]  = 8'h00;
        in_valid[0] = 1'b1;
        g_dut[0].exp_q.push_back(8'h00);
        @(negedge clk);
        in_data[0]  = 8'hFF;
        g_dut[0].exp_q.push_back(8'hFF);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("t2_start_tx", {31'd0, tx[0]},    32'd0);
        check("t2_level",    {29'd0, level[0]}, 32'd1);
        busy_len(0, 300, cnt);
        check("t2_busy_len", cnt, 32'd80);

        // Reset during data bit 3 of 0x5A with two bytes queued.
        repeat (2) @(negedge clk);
        in_data[0]  = 8'h5A;
        in_valid[0] = 1'b1;
        g_dut[0].exp_q.push_back(8'h5A);
        @(negedge clk);
        in_data[0]  = 8'h11;
        @(negedge clk);
        in_data[0]  = 8'h22;
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("t4_level_queued", {29'd0, level[0]}, 32'd2);
        repeat (16) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("t4_rst_tx",       {31'd0, tx[0]},       32'd1);
        check("t4_rst_tx_oe",    {31'd0, tx_oe[0]},    32'd0);
        check("t4_rst_level",    {29'd0, level[0]},    32'd0);
        check("t4_rst_busy",     {31'd0, busy[0]},     32'd0);
        rst[0] = 1'b0;
        @(negedge clk);
        check("t4_rel_tx_oe",    {31'd0, tx_oe[0]},    32'd1);
        check("t4_rel_in_ready", {31'd0, in_ready[0]}, 32'd1);
        g_dut[0].exp_q.delete();
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        check("t4_no_frame_after_rst", bad, 32'd0);

        // Minimum divider, 0x80 at CLK_DIV=2.
        in_data[2]  = 8'h80;
        in_valid[2] = 1'b1;
        g_dut[2].exp_q.push_back(8'h80);
        @(negedge clk);
        in_valid[2] = 1'b0;
        check("t6_level", {29'd0, level[2]}, 32'd1);
        @(negedge clk);
        check("t6_start_tx", {31'd0, tx[2]}, 32'd0);
        busy_len(2, 100, cnt);
        check("t6_busy_len", cnt, 32'd20);

        // Overflow at CLK_DIV=16: in_valid held across 0x01..0x06.
        for (int b = 1; b <= 6; b++) begin
            in_data[1]  = b[7:0];
            in_valid[1] = 1'b1;
            g_dut[1].exp_q.push_back(b[7:0]);
            if (b == 6) begin
                check("t3_full_level", {29'd0, level[1]},    32'd4);
                check("t3_full_ready", {31'd0, in_ready[1]}, 32'd0);
            end
            waited = 0;
            do begin
                acc = in_ready[1];
                @(negedge clk);
                waited++;
            end while (acc !== 1'b1 && waited < 400);
            check($sformatf("t3_accept_%0d", b), {31'd0, acc}, 32'd1);
            if (b == 2) t2 = cyc;
            if (b == 6) t6 = cyc;
        end
        in_valid[1] = 1'b0;
        // A full FIFO refuses while popping, so 0x06 lands one edge after 0x02 is popped.
        check("t3_accept_gap",    t6 - t2, 32'd161);
        check("t3_level_refill",  {29'd0, level[1]}, 32'd4);
        busy_len(1, 2000, cnt);
        check("t3_drained_busy",  {31'd0, busy[1]},  32'd0);
        check("t3_drained_level", {29'd0, level[1]}, 32'd0);

        repeat (5) @(negedge clk);
        check("q0_empty", g_dut[0].exp_q.size(), 32'd0);
        check("q1_empty", g_dut[1].exp_q.size(), 32'd0);
        check("q2_empty", g_dut[2].exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
